mux_sel_sampler: RTL and testbench

//   Select sequencer and sampler for the 4:1 mux stage. Arbitrates four request lines,

---
 rtl/mux_sel_sampler.sv | 164 ++++++++++++++++
 tb/tb_mux_sel_sampler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sampler.sv
// mux_sel_sampler: select sequencer and sampler for a 4:1 mux stage.
// Grants one of four level requests, drives the mux select, waits
// SETTLE_CYC extra cycles, captures mux Y and offers {channel, bit}
// downstream on a valid/ready port, then acks the serviced requester.
// Optional build macro: MUXSEL_FIXED_PRIO_EN selects fixed priority
// (ch0 highest) instead of the default round-robin arbitration.
//
// Handshake: out_valid rises with a captured sample and, together with
// out_bit/out_ch/sel, stays stable until a rising edge where
// out_valid && out_ready; that edge is the transfer, after which
// out_valid drops and ack pulses for one cycle on the serviced channel.
module mux_sel_sampler #(
   parameter int unsigned SETTLE_CYC = 1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       req,
   output logic [3:0]       ack,
   output logic [1:0]       sel,
   input  logic             mux_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [1:0]       out_ch,
   output logic             busy,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             out_bit_q, out_bit_d;
   logic [1:0]       out_ch_q, out_ch_d;
   logic [3:0]       ack_q, ack_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

   logic [1:0]       grant_ch;
   logic             grant_hit;
   logic [1:0]       idx;

   // Arbiter: pick the winning channel; higher priority candidates are
   // visited last so they overwrite lower ones.
   always_comb begin
      grant_ch  = 2'd0;
      grant_hit = 1'b0;
      idx       = 2'd0;
`ifdef MUXSEL_FIXED_PRIO_EN
      for (int i = 3; i >= 0; i--) begin
         idx = 2'(i);
         if (req[idx]) begin
            grant_ch  = idx;
            grant_hit = 1'b1;
         end
      end
`else
      // ptr+1 is the highest priority, ptr itself (i=4 wraps) the lowest.
      for (int i = 4; i >= 1; i--) begin
         idx = ptr_q + 2'(i);
         if (req[idx]) begin
            grant_ch  = idx;
            grant_hit = 1'b1;
         end
      end
`endif
   end

   // Next-state and datapath updates for the IDLE/SETTLE/HOLD sequencer.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_bit_d    = out_bit_q;
      out_ch_d     = out_ch_q;
      ack_d        = 4'b0000;
      ptr_d        = ptr_q;
      sample_cnt_d = sample_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (en && grant_hit) begin
               sel_d   = grant_ch;
               cnt_d   = SETTLE_INIT;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 4'd0) begin
               out_bit_d   = mux_y;
               out_ch_d    = sel_q;
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               ack_d       = 4'b0001 << out_ch_q;
`ifndef MUXSEL_FIXED_PRIO_EN
               ptr_d       = out_ch_q;
`endif
               if (sample_cnt_q != CNT_MAX) begin
                  sample_cnt_d = sample_cnt_q + CNT_ONE;
               end
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any sample in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sel_q        <= 2'd0;
         cnt_q        <= 4'd0;
         out_valid_q  <= 1'b0;
         out_bit_q    <= 1'b0;
         out_ch_q     <= 2'd0;
         ack_q        <= 4'b0000;
         ptr_q        <= 2'd3;
         sample_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_bit_q    <= out_bit_d;
         out_ch_q     <= out_ch_d;
         ack_q        <= ack_d;
         ptr_q        <= ptr_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   assign sel        = sel_q;
   assign out_valid  = out_valid_q;
   assign out_bit    = out_bit_q;
   assign out_ch     = out_ch_q;
   assign ack        = ack_q;
   assign sample_cnt = sample_cnt_q;
   assign busy       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mux_sel_sampler.sv
// Testbench for mux_sel_sampler (SETTLE_CYC=1, CNT_W=8). Expected
// {channel, bit} pairs are queued by the stimulus; a monitor pops and
// compares at every transfer and checks the following ack pulse.
// Expectations follow MUXSEL_FIXED_PRIO_EN when it is defined.
module tb_mux_sel_sampler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic [3:0] ack;
   logic [1:0] sel;
   logic       mux_y;
   logic       out_valid;
   logic       out_ready;
   logic       out_bit;
   logic [1:0] out_ch;
   logic       busy;
   logic [7:0] sample_cnt;
   logic [1:0] dbg_state;
   logic [3:0] mux_i;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pop    = 0;
   logic [2:0] exp_q[$];
   logic [3:0] exp_ack = 4'b0000;

   // clock / reset block
   always #5 clk = ~clk;

   assign mux_y = mux_i[sel];

   mux_sel_sampler #(.SETTLE_CYC(1), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ack(ack), .sel(sel),
      .mux_y(mux_y), .out_valid(out_valid), .out_ready(out_ready),
      .out_bit(out_bit), .out_ch(out_ch), .busy(busy),
      .sample_cnt(sample_cnt), .dbg_state(dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout got no event expected event at %0t", name, $time);
   endtask

   task automatic wait_pops(input int target, input int bound);
      for (int i = 0; i < bound && n_pop < target; i++) @(negedge clk);
      if (n_pop < target) fail_timeout("wait_pops");
   endtask

   task automatic wait_valid(input int bound);
      for (int i = 0; i < bound && !out_valid; i++) @(negedge clk);
      if (!out_valid) fail_timeout("wait_valid");
   endtask

   task automatic push(input logic [1:0] ch, input logic b);
      exp_q.push_back({ch, b});
   endtask

   // scoreboard monitor: compare at each transfer, then check the ack pulse
   always @(negedge clk) begin
      logic [2:0] e;
      logic [3:0] nxt;
      if (!rst_n) begin
         exp_ack = 4'b0000;
      end else begin
         check("ack", ack, exp_ack);
         nxt = 4'b0000;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_sample", out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("out_ch", out_ch, e[2:1]);
               check("out_bit", out_bit, e[0]);
               check("sel_at_xfer", sel, e[2:1]);
               nxt = 4'b0001 << e[2:1];
               n_pop++;
            end
         end
         exp_ack = nxt;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset with arbitrary inputs
      rst_n = 1'b0; en = 1'b1; req = 4'($urandom_range(0, 15));
      out_ready = 1'b1; mux_i = 4'($urandom_range(0, 15));
      repeat (2) @(negedge clk);
      check("rst_sel", sel, 2'd0);
      check("rst_ack", ack, 4'd0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_bit", out_bit, 1'b0);
      check("rst_ch", out_ch, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_cnt", sample_cnt, 8'd0);
      en = 1'b0; req = 4'b0000;
      rst_n = 1'b1;
      @(negedge clk);

      // 2: single request, cycle-exact latency
      mux_i = 4'b1010; req = 4'b0010; en = 1'b1; out_ready = 1'b1;
      push(2'd1, 1'b1);
      @(negedge clk);              // grant edge passed
      req = 4'b0000;               // request drops after the grant
      check("t2_sel", sel, 2'd1);
      check("t2_busy", busy, 1'b1);
      check("t2_valid_n0", out_valid, 1'b0);
      @(negedge clk);
      check("t2_valid_n1", out_valid, 1'b0);
      @(negedge clk);
      check("t2_valid_n2", out_valid, 1'b1);
      @(negedge clk);
      check("t2_valid_drop", out_valid, 1'b0);
      check("t2_cnt", sample_cnt, 8'd1);

      // 3: all requests held after a fresh reset -> arbitration order
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mux_i = 4'b1010;
`ifdef MUXSEL_FIXED_PRIO_EN
      for (int i = 0; i < 5; i++) push(2'd0, 1'b0);
`else
      push(2'd0, 1'b0); push(2'd1, 1'b1); push(2'd2, 1'b0);
      push(2'd3, 1'b1); push(2'd0, 1'b0);
`endif
      req = 4'b1111;
      wait_pops(n_pop + 5, 60);
      req = 4'b0000;
      repeat (2) @(negedge clk);
      check("t3_busy", busy, 1'b0);
      check("t3_cnt", sample_cnt, 8'd5);

      // 4: back-pressure; outputs stay stable while the mux input changes
      mux_i = 4'b1100; req = 4'b0100; out_ready = 1'b0;
      push(2'd2, 1'b1);
      wait_valid(10);
      req = 4'b0000; mux_i = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_valid", out_valid, 1'b1);
         check("t4_sel", sel, 2'd2);
         check("t4_ch", out_ch, 2'd2);
         check("t4_bit", out_bit, 1'b1);
      end
      out_ready = 1'b1;
      wait_pops(n_pop + 1, 10);
      repeat (2) @(negedge clk);
      check("t4_cnt", sample_cnt, 8'd6);

      // 5: reset during SETTLE discards the sample; ch0 wins afterwards
      mux_i = 4'b1010; req = 4'b1000;
      @(negedge clk);
      check("t5_busy", busy, 1'b1);
      check("t5_sel", sel, 2'd3);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_valid", out_valid, 1'b0);
      req = 4'b1001; mux_i = 4'b0001;
      push(2'd0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_regrant_sel", sel, 2'd0);
      check("t5_regrant_valid", out_valid, 1'b0);
      req = 4'b0000;
      wait_pops(n_pop + 1, 10);
      repeat (2) @(negedge clk);
      check("t5_cnt", sample_cnt, 8'd1);

      // en low blocks grants; en dropping mid-sample still completes it
      en = 1'b0; req = 4'b0010; mux_i = 4'b0001;
      repeat (4) begin
         @(negedge clk);
         check("en0_busy", busy, 1'b0);
         check("en0_sel", sel, 2'd0);
      end
      push(2'd1, 1'b0);
      en = 1'b1;
      @(negedge clk);
      check("en1_busy", busy, 1'b1);
      en = 1'b0;
      wait_pops(n_pop + 1, 10);
      repeat (3) begin
         @(negedge clk);
         check("en_drop_busy", busy, 1'b0);
         check("en_drop_sel", sel, 2'd1);
      end
      check("en_cnt", sample_cnt, 8'd2);

      // saturation of the completed-sample counter
      en = 1'b1; mux_i = 4'b0010; req = 4'b0010;
      for (int i = 0; i < 260; i++) push(2'd1, 1'b1);
      wait_pops(n_pop + 260, 1500);
      req = 4'b0000;
      repeat (2) @(negedge clk);
      check("sat_cnt", sample_cnt, 8'd255);
      check("sat_busy", busy, 1'b0);
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
